// File: rtl/fractal_pkg.sv
// Shared types and defaults for the fractal frame scheduler.
package fractal_pkg;

    localparam int unsigned DEF_X_SIZE = 640;
    localparam int unsigned DEF_Y_SIZE = 480;
    localparam logic [3:0]  TKEEP_ALL  = 4'b1111;

    typedef logic [31:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fractal_job_scheduler_axis_out_slice.sv
// Single-entry AXI4-Stream output register; accepts a new pixel whenever empty or draining.
module axis_out_slice
    import fractal_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  pixel_t data_i,
    input  logic   user_i,
    input  logic   last_i,
    input  logic   tready_i,
    output logic   tvalid_o,
    output pixel_t tdata_o,
    output logic   tuser_o,
    output logic   tlast_o,
    output logic   load_ok_c
);

    logic   tvalid_q;
    pixel_t tdata_q;
    logic   tuser_q;
    logic   tlast_q;

    // Payload only changes on load, so a stalled beat holds steady.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            tvalid_q <= 1'b1;
            tdata_q  <= data_i;
            tuser_q  <= user_i;
            tlast_q  <= last_i;
        end else if (tready_i) begin
            tvalid_q <= 1'b0;
        end
    end

    assign load_ok_c = !tvalid_q || tready_i;
    assign tvalid_o  = tvalid_q;
    assign tdata_o   = tdata_q;
    assign tuser_o   = tuser_q;
    assign tlast_o   = tlast_q;

endmodule

// File: rtl/fractal_job_scheduler.sv
// Raster-order job dispatch to a round-robin engine bank, with in-order retire to AXI4-Stream.
module fractal_job_scheduler
    import fractal_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned X_SIZE      = DEF_X_SIZE,
    parameter int unsigned Y_SIZE      = DEF_Y_SIZE,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 9
) (
    input  logic                     aclk,
    input  logic                     periph_reset,
    input  logic                     start,
    input  logic                     continuous,
    output logic                     busy,
    output logic                     frame_done,
    output logic [NUM_ENGINES-1:0]   job_valid,
    input  logic [NUM_ENGINES-1:0]   job_ready,
    output logic [XW-1:0]            job_x,
    output logic [YW-1:0]            job_y,
    input  logic [NUM_ENGINES-1:0]   res_valid,
    output logic [NUM_ENGINES-1:0]   res_ready,
    input  logic [32*NUM_ENGINES-1:0] res_data,
    output logic [31:0]              out_stream_tdata,
    output logic [3:0]               out_stream_tkeep,
    output logic                     out_stream_tvalid,
    input  logic                     out_stream_tready,
    output logic                     out_stream_tuser,
    output logic                     out_stream_tlast
);

    localparam int unsigned PW       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned CW       = XW + YW;
    localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(X_SIZE * Y_SIZE - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_ENGINES - 1);

    state_e                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [PW-1:0]          d_ptr_q, d_ptr_d;
    logic [PW-1:0]          r_ptr_q, r_ptr_d;
    logic [NUM_ENGINES-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_ENGINES-1:0] job_valid_c;
    logic [NUM_ENGINES-1:0] res_ready_c;
    logic                   dispatch_ok, job_fire;
    logic                   retire_ok, res_fire, last_fire;
    logic                   load_ok_c;
    logic                   tvalid, tlast;
    pixel_t                 res_slice [NUM_ENGINES];

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_slice
        assign res_slice[g] = res_data[32*g +: 32];
    end

    always_ff @(posedge aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            d_ptr_q      <= '0;
            r_ptr_q      <= '0;
            in_flight_q  <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            d_ptr_q      <= d_ptr_d;
            r_ptr_q      <= r_ptr_d;
            in_flight_q  <= in_flight_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        d_ptr_d      = d_ptr_q;
        r_ptr_d      = r_ptr_q;
        in_flight_d  = in_flight_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        job_valid_c  = '0;
        res_ready_c  = '0;

        // Dispatch looks only at the registered flag, so a just-retired engine waits a cycle.
        dispatch_ok = (state_q == RUN) && !in_flight_q[d_ptr_q];
        job_fire    = dispatch_ok && job_ready[d_ptr_q];
        retire_ok   = (state_q != IDLE) && load_ok_c;
        res_fire    = retire_ok && res_valid[r_ptr_q];
        last_fire   = (state_q != IDLE) && tvalid && out_stream_tready && tlast;

        job_valid_c[d_ptr_q] = dispatch_ok;
        res_ready_c[r_ptr_q] = retire_ok;

        if (res_fire) begin
            in_flight_d[r_ptr_q] = 1'b0;
            r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PW'(1);
            cnt_d   = cnt_q + CW'(1);
        end

        if (job_fire) begin
            in_flight_d[d_ptr_q] = 1'b1;
            d_ptr_d = (d_ptr_q == PTR_LAST) ? '0 : d_ptr_q + PW'(1);
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    d_ptr_d = '0;
                    r_ptr_d = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (job_fire && (x_q == X_LAST) && (y_q == Y_LAST)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        if (last_fire) begin
            frame_done_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
            d_ptr_d      = '0;
            r_ptr_d      = '0;
            cnt_d        = '0;
            if (continuous) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    axis_out_slice u_out (
        .clk_i     (aclk),
        .rst_i     (periph_reset),
        .load_i    (res_fire),
        .data_i    (res_slice[r_ptr_q]),
        .user_i    (cnt_q == '0),
        .last_i    (cnt_q == CNT_LAST),
        .tready_i  (out_stream_tready),
        .tvalid_o  (tvalid),
        .tdata_o   (out_stream_tdata),
        .tuser_o   (out_stream_tuser),
        .tlast_o   (tlast),
        .load_ok_c (load_ok_c)
    );

    assign out_stream_tvalid = tvalid;
    assign out_stream_tlast  = tlast;
    assign out_stream_tkeep  = TKEEP_ALL;
    assign job_valid         = job_valid_c;
    assign res_ready         = res_ready_c;
    assign job_x             = x_q;
    assign job_y             = y_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_fractal_job_scheduler.sv
// Directed bench: 4 modelled engines on an 8x2 frame, scoreboarded output stream.
module tb_fractal_job_scheduler;

    localparam int NE = 4;
    localparam int XS = 8;
    localparam int YS = 2;
    localparam int XW = 3;
    localparam int YW = 1;

    logic              aclk = 1'b0;
    logic              periph_reset;
    logic              start;
    logic              continuous;
    logic              busy;
    logic              frame_done;
    logic [NE-1:0]     job_valid;
    logic [NE-1:0]     job_ready;
    logic [XW-1:0]     job_x;
    logic [YW-1:0]     job_y;
    logic [NE-1:0]     res_valid;
    logic [NE-1:0]     res_ready;
    logic [32*NE-1:0]  res_data;
    logic [31:0]       tdata;
    logic [3:0]        tkeep;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    frames = 0;
    int    beats = 0;
    int    lat[NE];
    bit    tog = 0;
    bit    stall_mode = 0;
    int    sd[NE];
    int    sd_max = 0;

    // engine model state
    logic [NE-1:0] eng_busy, eng_rv;
    int            eng_cnt[NE];
    logic [31:0]   eng_data[NE];
    logic [NE-1:0] job_hs, res_hs;
    logic [XW-1:0] hs_x;
    logic [YW-1:0] hs_y;

    logic          prev_stall = 0;
    logic [33:0]   prev_beat = '0;
    logic          prev_last_hs = 0;

    always #5 aclk = ~aclk;

    fractal_job_scheduler #(
        .NUM_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS), .XW(XW), .YW(YW)
    ) dut (
        .aclk              (aclk),
        .periph_reset      (periph_reset),
        .start             (start),
        .continuous        (continuous),
        .busy              (busy),
        .frame_done        (frame_done),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_x             (job_x),
        .job_y             (job_y),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready),
        .out_stream_tuser  (tuser),
        .out_stream_tlast  (tlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    assign job_ready = ~eng_busy;
    assign res_valid = eng_rv;
    for (genvar g = 0; g < NE; g++) begin : g_res
        assign res_data[32*g +: 32] = eng_data[g];
    end

    // Engines: accept when idle, return {y,x} after lat[i] cycles, hold until retired.
    always @(posedge aclk or posedge periph_reset) begin
        if (periph_reset) begin
            eng_busy <= '0;
            eng_rv   <= '0;
            for (int i = 0; i < NE; i++) begin
                eng_cnt[i]  <= 0;
                eng_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (job_hs[i]) begin
                    eng_busy[i] <= 1'b1;
                    eng_cnt[i]  <= lat[i];
                    eng_data[i] <= 32'({hs_y, hs_x});
                end else if (eng_busy[i] && !eng_rv[i]) begin
                    if (eng_cnt[i] <= 1) eng_rv[i] <= 1'b1;
                    else eng_cnt[i] <= eng_cnt[i] - 1;
                end
                if (res_hs[i]) begin
                    eng_rv[i]   <= 1'b0;
                    eng_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Negedge sampler: engine handshakes, scoreboard, stall and frame_done checks.
    always @(negedge aclk) begin
        job_hs = job_valid & job_ready;
        res_hs = res_valid & res_ready;
        hs_x   = job_x;
        hs_y   = job_y;
        if (periph_reset) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 64'({tvalid, tdata, tuser, tlast}), 64'({1'b1, prev_beat}));
            if (tvalid && !tready) chk("res_ready_in_stall", 64'(res_ready), 64'd0);
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("beat", 64'({tdata, tuser, tlast}), 64'(exp_q.pop_front()));
                end
                beats++;
            end
            if (prev_last_hs || frame_done) begin
                chk("frame_done_pulse", 64'(frame_done), 64'(prev_last_hs));
                if (frame_done) begin
                    chk("busy_at_done", 64'(busy), 64'(continuous));
                    frames++;
                end
            end
            if (stall_mode) begin
                if (job_hs[1]) begin
                    for (int i = 0; i < NE; i++) sd[i] = 0;
                end else if (eng_busy[1]) begin
                    for (int i = 0; i < NE; i++) begin
                        if (i != 1 && job_hs[i]) begin
                            sd[i]++;
                            if (sd[i] > sd_max) sd_max = sd[i];
                        end
                    end
                end
            end
            prev_stall   = tvalid && !tready;
            prev_beat    = {tdata, tuser, tlast};
            prev_last_hs = tvalid && tready && tlast;
        end
    end

    task automatic push_frame();
        beat_t b;
        for (int yy = 0; yy < YS; yy++) begin
            for (int xx = 0; xx < XS; xx++) begin
                b.d = 32'((yy << XW) | xx);
                b.u = (xx == 0) && (yy == 0);
                b.l = (xx == XS - 1) && (yy == YS - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge aclk); #1 start = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input bit watch, output int busy_low);
        int c;
        c = 0;
        busy_low = 0;
        while (frames < target && c < budget) begin
            @(posedge aclk); #1;
            c++;
            if (tog) tready = ((c % 3) == 0);
            if (watch && !busy) busy_low++;
        end
        chk("frame_within_budget", 64'(frames >= target), 64'd1);
    endtask

    initial begin
        int f0, bl, b0, c;
        periph_reset = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        tready       = 1'b0;
        lat          = '{3, 7, 1, 5};
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_job_valid",  64'(job_valid),  64'd0);
        chk("rst_res_ready",  64'(res_ready),  64'd0);
        chk("rst_tvalid",     64'(tvalid),     64'd0);
        chk("rst_tdata",      64'(tdata),      64'd0);
        chk("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
        chk("tkeep",          64'(tkeep),      64'hF);
        @(posedge aclk); #1 periph_reset = 1'b0;

        // Full-throughput frame
        tready = 1'b1;
        f0 = frames;
        push_frame();
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_frames(f0 + 1, 500, 1'b0, bl);
        @(posedge aclk); #1;
        chk("busy_idle_after_frame", 64'(busy), 64'd0);

        // Backpressure 1-on/2-off
        tog = 1'b1;
        f0 = frames;
        push_frame();
        pulse_start();
        wait_frames(f0 + 1, 1000, 1'b0, bl);
        tog = 1'b0;
        tready = 1'b1;

        // Slow engine 1
        lat[1] = 40;
        stall_mode = 1'b1;
        f0 = frames;
        push_frame();
        pulse_start();
        wait_frames(f0 + 1, 2000, 1'b0, bl);
        stall_mode = 1'b0;
        lat[1] = 7;
        chk("stall_dispatch_max", 64'(sd_max), 64'd1);

        // Reset in the middle of a frame
        f0 = frames;
        push_frame();
        b0 = beats;
        pulse_start();
        c = 0;
        while (beats < b0 + 7 && c < 500) begin
            @(posedge aclk); #1;
            c++;
        end
        chk("reached_beat6", 64'(beats >= b0 + 7), 64'd1);
        periph_reset = 1'b1;
        #1;
        chk("midrst_outputs", 64'({busy, frame_done, job_valid, res_ready, tvalid, tuser, tlast}), 64'd0);
        chk("midrst_tdata", 64'(tdata), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 periph_reset = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("idle_after_rst", 64'({busy, job_valid}), 64'd0);
        push_frame();
        pulse_start();
        wait_frames(f0 + 1, 500, 1'b0, bl);

        // Two back-to-back frames in continuous mode
        continuous = 1'b1;
        f0 = frames;
        push_frame();
        push_frame();
        pulse_start();
        wait_frames(f0 + 1, 500, 1'b1, bl);
        chk("busy_low_cycles_cont", 64'(bl), 64'd0);
        chk("busy_cont_restart", 64'(busy), 64'd1);
        continuous = 1'b0;
        wait_frames(f0 + 2, 500, 1'b0, bl);

        // start during RUN is ignored
        f0 = frames;
        push_frame();
        pulse_start();
        repeat (10) @(posedge aclk);
        pulse_start();
        wait_frames(f0 + 1, 500, 1'b0, bl);
        repeat (40) @(posedge aclk);
        #1;
        chk("no_extra_frame", 64'(frames), 64'(f0 + 1));
        chk("idle_at_end", 64'(busy), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fractal_job_scheduler.md
Name: fractal_job_scheduler

Overview:
- Frame-level controller sitting between the AXI-Lite control registers and a bank of NUM_ENGINES fractal iteration engines, upstream of the output video stream.
- Walks raster coordinates (x,y) and dispatches one pixel job at a time to the engines in strict round-robin order.
- Retires engine results in the same round-robin order, so pixels leave in raster order.
- Drives the 32-bit AXI4-Stream output, with tuser on the first pixel of a frame and tlast on the last pixel of a frame.

Parameters:
- NUM_ENGINES, 4: number of iteration engines; must be a power of two, 1..16.
- X_SIZE, 640: pixels per line.
- Y_SIZE, 480: lines per frame.
- XW, 10: width of the x coordinate; must hold X_SIZE-1.
- YW, 9: width of the y coordinate; must hold Y_SIZE-1.

Ports:
- aclk  in  1  sole clock.
- periph_reset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a frame when idle.
- continuous  in  1  when high, the next frame starts automatically after frame end.
- busy  out  1  high from frame start until the final beat is accepted.
- frame_done  out  1  one-cycle pulse on acceptance of the tlast beat.
- job_valid  out  NUM_ENGINES  one-hot job request per engine.
- job_ready  in  NUM_ENGINES  per-engine job accept.
- job_x  out  XW  job x coordinate; shared by all engines.
- job_y  out  YW  job y coordinate; shared by all engines.
- res_valid  in  NUM_ENGINES  per-engine result valid.
- res_ready  out  NUM_ENGINES  one-hot result accept.
- res_data  in  32*NUM_ENGINES  packed RGBX results; engine i occupies bits [32i+31:32i].
- out_stream_tdata  out  32  pixel.
- out_stream_tkeep  out  4  constant 4'b1111.
- out_stream_tvalid  out  1  stream valid.
- out_stream_tready  in  1  stream ready.
- out_stream_tuser  out  1  start of frame; high with pixel (0,0).
- out_stream_tlast  out  1  end of frame; high with pixel (X_SIZE-1, Y_SIZE-1).

Behaviour:
- Clock and reset: one clock (aclk); reset periph_reset is asynchronous and active-high.
- Reset values: state IDLE; busy, frame_done, job_valid, res_ready, tvalid, tuser, tlast = 0; tdata = 0; all counters and pointers = 0; per-engine in_flight flags = 0.
- Reset asserted mid-frame: all jobs in flight are abandoned. After release the block stays in IDLE until the next start.
- State IDLE: on start=1 -> RUN next cycle; x, y, d_ptr, r_ptr are cleared.
- State RUN, dispatch:
  - job_valid[d_ptr] = !in_flight[d_ptr]; job_x/job_y carry the current coordinate.
  - On job_valid & job_ready: set in_flight[d_ptr]; d_ptr++ (wraps at NUM_ENGINES).
  - On the same handshake, advance the coordinate: x++; when x==X_SIZE-1, x wraps to 0 and y++.
  - On the handshake for (X_SIZE-1, Y_SIZE-1): -> DRAIN.
- State DRAIN: no job_valid; the retire path continues.
- Retire path (RUN and DRAIN):
  - res_ready[r_ptr] = !tvalid | tready; no other engine is ever granted.
  - On res_valid & res_ready: load tdata from slice r_ptr, set tvalid, clear in_flight[r_ptr], r_ptr++.
  - tuser = (retire count == 0); tlast = (retire count == X_SIZE*Y_SIZE-1).
  - Latency: result handshake -> tvalid on the next edge. Full throughput at one pixel per cycle when tready is held high.
- Simultaneous events:
  - A dispatch and a retire on the same engine in the same cycle is legal only after in_flight has cleared. Dispatch checks the registered flag, so the engine is re-dispatched the following cycle.
  - Dispatch and retire on different engines in one cycle are independent.
- Output stall: while tvalid=1 and tready=0, tdata, tuser and tlast hold and res_ready stays 0. This is AXI-S compliant: once tvalid rises it never drops without a handshake.
- Frame end:
  - The tlast beat accepted -> frame_done pulses for one cycle.
  - If continuous=1: the block enters RUN the next cycle with counters cleared, keeping busy=1.
  - Otherwise: IDLE and busy=0.
- start outside IDLE is ignored.
- Width rules: the retire counter is XW+YW bits. Comparisons use constants sized to that width; no truncation.

Decomposition:
- Package fractal_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - default X_SIZE/Y_SIZE constants;
  - TKEEP_ALL = 4'b1111;
  - a pixel_t typedef (32-bit).
- One sub-module: axis_out_slice, a single-entry output register covering tvalid/tdata/tuser/tlast plus the load-enable logic.
- Round-robin pointers and coordinate counters stay inline.

Test Plan (NUM_ENGINES=4, X_SIZE=8, Y_SIZE=2, engines modelled with latencies 3/7/1/5, each returning {y,x} as data):
- start pulse with tready=1 -> 16 beats in raster order (tdata x=0..7, y=0 then 1); tuser only on beat 0; tlast only on beat 15; frame_done one cycle after the final handshake; busy falls the same cycle.
- tready toggled on a 1-on/2-off pattern -> identical 16-beat sequence; tdata stable during stalls; no dropped or duplicated beats.
- Engine 1 forced to latency 40 -> no beat emitted past engine 1's slot until its result arrives; other engines dispatch at most one job each while stalled.
- periph_reset pulsed after beat 6 -> all outputs 0 immediately; a fresh start yields a full 16-beat frame with tuser on (0,0).
- continuous=1 with two frames -> 32 beats, with tuser on beats 0 and 16 and tlast on beats 15 and 31; busy stays high throughout.
- start pulsed during RUN -> ignored; frame count and beat sequence unchanged.
